// File: rtl/traffic_phase_ctrl.sv
// Crossroads phase sequencer: NS/EW lamps, per-phase countdown, pedestrian shortening, emergency flash.
// Latency: every output registered, 1 clk after the causing edge; no backpressure, tick_1s is consumed when seen.
module traffic_phase_ctrl #(
  parameter int T_GREEN   = 30,
  parameter int T_YELLOW  = 3,
  parameter int T_ALLRED  = 2,
  parameter int T_PED_MIN = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       ped_req,
  input  logic       emergency,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [6:0] countdown,
  output logic [2:0] phase,
  output logic       walk
);

  typedef enum logic [2:0] {
    NS_GREEN = 3'd0,
    NS_YEL   = 3'd1,
    RED_A    = 3'd2,
    EW_GREEN = 3'd3,
    EW_YEL   = 3'd4,
    RED_B    = 3'd5,
    EMERG    = 3'd6
  } state_t;

  localparam logic [6:0] DUR_GREEN  = 7'(T_GREEN);
  localparam logic [6:0] DUR_YELLOW = 7'(T_YELLOW);
  localparam logic [6:0] DUR_ALLRED = 7'(T_ALLRED);
  localparam logic [6:0] PED_MIN    = 7'(T_PED_MIN);

  state_t state;
  state_t adv;
  logic   ped_pending;
  logic   blink;
  logic   in_green;

  function automatic state_t next_of(input state_t s);
    case (s)
      NS_GREEN: next_of = NS_YEL;
      NS_YEL:   next_of = RED_A;
      RED_A:    next_of = EW_GREEN;
      EW_GREEN: next_of = EW_YEL;
      EW_YEL:   next_of = RED_B;
      default:  next_of = NS_GREEN;
    endcase
  endfunction

  function automatic logic [6:0] dur_of(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN: dur_of = DUR_GREEN;
      NS_YEL, EW_YEL:     dur_of = DUR_YELLOW;
      default:            dur_of = DUR_ALLRED;
    endcase
  endfunction

  // {ns_light, ew_light}, each {R,Y,G}
  function automatic logic [5:0] lamps_of(input state_t s, input logic b);
    case (s)
      NS_GREEN: lamps_of = {3'b001, 3'b100};
      NS_YEL:   lamps_of = {3'b010, 3'b100};
      EW_GREEN: lamps_of = {3'b100, 3'b001};
      EW_YEL:   lamps_of = {3'b100, 3'b010};
      EMERG:    lamps_of = {1'b0, b, 1'b0, 1'b0, b, 1'b0};
      default:  lamps_of = {3'b100, 3'b100};
    endcase
  endfunction

  assign adv      = next_of(state);
  assign in_green = (state == NS_GREEN) || (state == EW_GREEN);
  assign phase    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= NS_GREEN;
      countdown            <= DUR_GREEN;
      {ns_light, ew_light} <= lamps_of(NS_GREEN, 1'b0);
      walk                 <= 1'b0;
      ped_pending          <= 1'b0;
      blink                <= 1'b0;
    end else begin
      if (ped_req)
        ped_pending <= 1'b1;

      if (state != EMERG && emergency) begin
        state                <= EMERG;
        countdown            <= 7'd0;
        walk                 <= 1'b0;
        blink                <= 1'b1;
        {ns_light, ew_light} <= lamps_of(EMERG, 1'b1);
      end else if (state == EMERG) begin
        // Exit always lands in an all-red clearance; a held ped request is served at the next RED entry.
        if (!emergency) begin
          state                <= RED_B;
          countdown            <= DUR_ALLRED;
          walk                 <= 1'b0;
          blink                <= 1'b0;
          {ns_light, ew_light} <= lamps_of(RED_B, 1'b0);
        end else if (tick_1s) begin
          blink                <= ~blink;
          {ns_light, ew_light} <= lamps_of(EMERG, ~blink);
        end
      end else if (tick_1s) begin
        if (countdown == 7'd1) begin
          state                <= adv;
          countdown            <= dur_of(adv);
          {ns_light, ew_light} <= lamps_of(adv, 1'b0);
          if (adv == RED_A || adv == RED_B) begin
            walk        <= ped_pending;
            ped_pending <= ped_req;
          end else begin
            walk <= 1'b0;
          end
        end else if (in_green && ped_pending && countdown > PED_MIN) begin
          countdown <= PED_MIN;
        end else begin
          countdown <= countdown - 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed plus randomized stimulus against a table-driven model of the phase sequencer.
module tb_traffic_phase_ctrl;

  localparam int TG = 5, TY = 2, TR = 1, TP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1s = 1'b0;
  logic       ped_req = 1'b0;
  logic       emergency = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic [6:0] countdown;
  logic       walk;

  traffic_phase_ctrl #(.T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TR), .T_PED_MIN(TP)) dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .ped_req(ped_req), .emergency(emergency),
    .ns_light(ns_light), .ew_light(ew_light), .countdown(countdown), .phase(phase), .walk(walk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: phase index 0..5 in ring order, 6 = emergency flash.
  int m_ph, m_cnt;
  bit m_walk, m_ped, m_blink;
  int DUR[6] = '{TG, TY, TR, TG, TY, TR};

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int exp_ns(input int ph, input bit b);
    case (ph)
      0: return 3'b001;
      1: return 3'b010;
      6: return b ? 3'b010 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  function automatic int exp_ew(input int ph, input bit b);
    case (ph)
      3: return 3'b001;
      4: return 3'b010;
      6: return b ? 3'b010 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  task automatic model_step(input bit t, input bit p, input bit e, input bit r);
    bit old_ped;
    if (r) begin
      m_ph = 0; m_cnt = TG; m_walk = 0; m_ped = 0; m_blink = 0;
      return;
    end
    old_ped = m_ped;
    m_ped = old_ped | p;
    if (m_ph != 6 && e) begin
      m_ph = 6; m_cnt = 0; m_walk = 0; m_blink = 1;
    end else if (m_ph == 6) begin
      if (!e) begin
        m_ph = 5; m_cnt = TR; m_walk = 0; m_blink = 0;
      end else if (t) begin
        m_blink = !m_blink;
      end
    end else if (t) begin
      if (m_cnt == 1) begin
        m_ph = (m_ph + 1) % 6;
        m_cnt = DUR[m_ph];
        if (m_ph == 2 || m_ph == 5) begin
          m_walk = old_ped;
          m_ped = p;
        end else begin
          m_walk = 0;
        end
      end else if ((m_ph == 0 || m_ph == 3) && old_ped && m_cnt > TP) begin
        m_cnt = TP;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("phase", int'(phase), m_ph);
    chk("countdown", int'(countdown), m_cnt);
    chk("ns_light", int'(ns_light), exp_ns(m_ph, m_blink));
    chk("ew_light", int'(ew_light), exp_ew(m_ph, m_blink));
    chk("walk", int'(walk), int'(m_walk));
    if (m_ph != 6)
      chk("both_nonred", int'(ns_light != 3'b100 && ew_light != 3'b100), 0);
  endtask

  // One clock: tick fires on every 10th cycle.
  task automatic step(input bit p, input bit e, input bit r);
    bit t;
    t = ((cyc % 10) == 9);
    tick_1s = t; ped_req = p; emergency = e; rst = r;
    @(posedge clk);
    model_step(t, p, e, r);
    cyc++;
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic run_ticks(input int n, input bit e);
    int k;
    k = 0;
    while (k < n) begin
      if ((cyc % 10) == 9) k++;
      step(1'b0, e, 1'b0);
    end
  endtask

  task automatic wait_tick_slot(input bit e);
    while ((cyc % 10) != 9) step(1'b0, e, 1'b0);
  endtask

  task automatic aligned_reset();
    wait_tick_slot(1'b0);
    step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bit em;
    m_ph = 0; m_cnt = TG; m_walk = 0; m_ped = 0; m_blink = 0;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_phase", int'(phase), 0);
    chk("rst_count", int'(countdown), TG);
    chk("rst_ns", int'(ns_light), 3'b001);
    chk("rst_ew", int'(ew_light), 3'b100);
    chk("rst_walk", int'(walk), 0);

    // Free run through one full NS half and into EW_YEL.
    run_ticks(13, 1'b0);
    chk("free_ph13", int'(phase), 4);
    chk("free_cnt13", int'(countdown), TY);

    // Pedestrian request while countdown is at full green.
    aligned_reset();
    step(1'b1, 1'b0, 1'b0);
    run_ticks(1, 1'b0);
    chk("ped_reload", int'(countdown), TP);
    run_ticks(2, 1'b0);
    chk("ped_nsyel", int'(phase), 1);
    run_ticks(2, 1'b0);
    chk("ped_reda_walk", int'(walk), 1);
    run_ticks(1, 1'b0);
    chk("ped_ewg_walk", int'(walk), 0);

    // Pedestrian request at countdown == T_PED_MIN: no reload.
    aligned_reset();
    run_ticks(3, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_ticks(1, 1'b0);
    chk("ped_late_cnt", int'(countdown), 1);
    run_ticks(3, 1'b0);
    chk("ped_late_ph", int'(phase), 2);
    chk("ped_late_walk", int'(walk), 1);

    // Emergency mid EW_GREEN on a tick, with a ped request pending.
    run_ticks(2, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    wait_tick_slot(1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("em_phase", int'(phase), 6);
    chk("em_count", int'(countdown), 0);
    chk("em_ns", int'(ns_light), 3'b010);
    chk("em_ew", int'(ew_light), 3'b010);
    run_ticks(1, 1'b1);
    chk("em_blink_ns", int'(ns_light), 3'b000);
    chk("em_blink_ew", int'(ew_light), 3'b000);
    run_ticks(2, 1'b1);

    // Release: all-red clearance, then NS_GREEN; held ped request served at RED_A.
    step(1'b0, 1'b0, 1'b0);
    chk("ex_phase", int'(phase), 5);
    chk("ex_count", int'(countdown), TR);
    chk("ex_walk", int'(walk), 0);
    run_ticks(1, 1'b0);
    chk("ex_nsg", int'(phase), 0);
    chk("ex_nsg_cnt", int'(countdown), TG);
    run_ticks(5, 1'b0);
    chk("ex_reda", int'(phase), 2);
    chk("ex_reda_walk", int'(walk), 1);

    // Reset mid EW_YEL coincident with a tick.
    for (int i = 0; i < 500 && m_ph != 4; i++) step(1'b0, 1'b0, 1'b0);
    chk("reach_ewyel", int'(phase), 4);
    wait_tick_slot(1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("rst2_phase", int'(phase), 0);
    chk("rst2_count", int'(countdown), TG);
    chk("rst2_ns", int'(ns_light), 3'b001);
    chk("rst2_ew", int'(ew_light), 3'b100);

    // Randomized traffic: sparse ped presses, emergency episodes, rare resets.
    em = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!em && $urandom_range(0, 399) == 0) em = 1;
      else if (em && $urandom_range(0, 59) == 0) em = 0;
      step($urandom_range(0, 49) == 0, em, $urandom_range(0, 1499) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
